// File: rtl/fu_cdb_arb_pkg.sv
// fu_cdb_arb_pkg: shared widths, source indices and the queued result
// record for the CDB arbiter and its per-source queues.
package fu_cdb_arb_pkg;

    localparam int unsigned NUM_SRC   = 3;
    localparam int unsigned PRF_IDX_W = 6;
    localparam int unsigned ROB_IDX_W = 5;
    localparam int unsigned BR_MASK_W = 4;

    localparam logic [PRF_IDX_W-1:0] ZERO_REG = '0;

    localparam int unsigned SRC_ALU  = 0;
    localparam int unsigned SRC_MULT = 1;
    localparam int unsigned SRC_LD   = 2;

    typedef logic [1:0] src_idx_t;

    typedef struct packed {
        logic [PRF_IDX_W-1:0] tag;
        logic [63:0]          value;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [BR_MASK_W-1:0] br_mask;
    } cdb_entry_t;

    // Round-robin successor of a source index (wraps NUM_SRC-1 -> 0).
    function automatic src_idx_t next_src(input src_idx_t s);
        return (s == src_idx_t'(NUM_SRC - 1)) ? '0 : s + src_idx_t'(1);
    endfunction

endpackage

// File: rtl/fu_cdb_arb_src_queue.sv
// cdb_src_queue: in-order result queue for one functional unit.
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_push, i_push_entry  incoming result
//   i_pop                 head was broadcast this cycle
//   i_recovery, i_pred_correct, i_tag_fix  branch resolution
//   o_head_*              head entry (valid/tag/value/rob_idx)
//   o_full                registered occupancy equals QDEPTH
//   o_ovf                 incoming result dropped this cycle (queue full)
module cdb_src_queue
    import fu_cdb_arb_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  cdb_entry_t           i_push_entry,
    input  logic                 i_pop,
    input  logic                 i_recovery,
    input  logic                 i_pred_correct,
    input  logic [BR_MASK_W-1:0] i_tag_fix,
    output logic                 o_head_vld,
    output logic [PRF_IDX_W-1:0] o_head_tag,
    output logic [63:0]          o_head_value,
    output logic [ROB_IDX_W-1:0] o_head_rob_idx,
    output logic                 o_full,
    output logic                 o_ovf
);

    logic [QDEPTH-1:0] r_vld;
    cdb_entry_t        r_ent     [QDEPTH];
    logic [QDEPTH-1:0] w_vld_nxt;
    cdb_entry_t        w_ent_nxt [QDEPTH];
    cdb_entry_t        w_in;
    cdb_entry_t        w_e;
    logic              w_in_kill;
    logic              w_keep;
    logic              w_ovf;

    // Pop, squash and mask-clear are applied to each stored entry, then the
    // survivors are packed from slot 0 upward (k = next free slot) and the
    // incoming result lands in slot k.
    always_comb begin
        int unsigned k;
        k         = 0;
        w_vld_nxt = '0;
        w_ovf     = 1'b0;
        w_e       = '0;
        w_keep    = 1'b0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            w_ent_nxt[i] = r_ent[i];
        end

        w_in      = i_push_entry;
        w_in_kill = i_recovery && (|(i_push_entry.br_mask & i_tag_fix));
        if (i_pred_correct) begin
            w_in.br_mask = i_push_entry.br_mask & ~i_tag_fix;
        end

        for (int unsigned i = 0; i < QDEPTH; i++) begin
            w_e = r_ent[i];
            if (i_pred_correct) begin
                w_e.br_mask = r_ent[i].br_mask & ~i_tag_fix;
            end
            w_keep = r_vld[i] && !((i == 0) && i_pop)
                     && !(i_recovery && (|(r_ent[i].br_mask & i_tag_fix)));
            if (w_keep) begin
                for (int unsigned j = 0; j < QDEPTH; j++) begin
                    if (j == k) begin
                        w_vld_nxt[j] = 1'b1;
                        w_ent_nxt[j] = w_e;
                    end
                end
                k = k + 1;
            end
        end

        // Overflow is judged on the registered occupancy: a squash freeing
        // slots this cycle does not rescue the incoming result.
        if (i_push && !w_in_kill) begin
            if (r_vld[QDEPTH-1] && !i_pop) begin
                w_ovf = 1'b1;
            end else begin
                for (int unsigned j = 0; j < QDEPTH; j++) begin
                    if (j == k) begin
                        w_vld_nxt[j] = 1'b1;
                        w_ent_nxt[j] = w_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                r_ent[i] <= w_ent_nxt[i];
            end
        end
    end

    assign o_head_vld     = r_vld[0];
    assign o_head_tag     = r_ent[0].tag;
    assign o_head_value   = r_ent[0].value;
    assign o_head_rob_idx = r_ent[0].rob_idx;
    assign o_full         = r_vld[QDEPTH-1];
    assign o_ovf          = w_ovf;

endmodule

// File: rtl/fu_cdb_arb.sv
// fu_cdb_arb: collects results from ALU/MULT/LD into per-source queues and
// broadcasts one head per cycle on the CDB, round-robin.
//   clk, rst                       clock, synchronous active-high reset
//   src_*_i                        per-source result inputs
//   rob_br_*_i                     branch recovery / correct-prediction
//   src_full_o                     per-source queue full (stall upstream)
//   cdb_vld_o/tag/value/rob_idx    broadcast result
//   ovf_err_o                      sticky enqueue-into-full flag
module fu_cdb_arb
    import fu_cdb_arb_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_SRC-1:0]                  src_vld_i,
    input  logic [NUM_SRC-1:0][PRF_IDX_W-1:0]   src_tag_i,
    input  logic [NUM_SRC-1:0][63:0]            src_value_i,
    input  logic [NUM_SRC-1:0][ROB_IDX_W-1:0]   src_rob_idx_i,
    input  logic [NUM_SRC-1:0][BR_MASK_W-1:0]   src_br_mask_i,
    input  logic                                rob_br_recovery_i,
    input  logic                                rob_br_pred_correct_i,
    input  logic [BR_MASK_W-1:0]                rob_br_tag_fix_i,
    output logic [NUM_SRC-1:0]                  src_full_o,
    output logic                                cdb_vld_o,
    output logic [PRF_IDX_W-1:0]                cdb_tag_o,
    output logic [63:0]                         cdb_value_o,
    output logic [ROB_IDX_W-1:0]                cdb_rob_idx_o,
    output logic                                ovf_err_o
);

    src_idx_t             r_rr_ptr;
    logic                 r_ovf;

    logic [NUM_SRC-1:0]   w_head_vld;
    logic [PRF_IDX_W-1:0] w_head_tag   [NUM_SRC];
    logic [63:0]          w_head_value [NUM_SRC];
    logic [ROB_IDX_W-1:0] w_head_rob   [NUM_SRC];
    logic [NUM_SRC-1:0]   w_pop;
    logic [NUM_SRC-1:0]   w_ovf;
    logic                 w_grant_vld;
    src_idx_t             w_grant_idx;
    src_idx_t             w_cand;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_queue
        cdb_entry_t w_push_entry;
        assign w_push_entry = '{tag:     src_tag_i[g],
                                value:   src_value_i[g],
                                rob_idx: src_rob_idx_i[g],
                                br_mask: src_br_mask_i[g]};
        assign w_pop[g] = w_grant_vld && (w_grant_idx == src_idx_t'(g));

        cdb_src_queue #(
            .QDEPTH (QDEPTH)
        ) u_queue (
            .i_clk          (clk),
            .i_rst          (rst),
            .i_push         (src_vld_i[g]),
            .i_push_entry   (w_push_entry),
            .i_pop          (w_pop[g]),
            .i_recovery     (rob_br_recovery_i),
            .i_pred_correct (rob_br_pred_correct_i),
            .i_tag_fix      (rob_br_tag_fix_i),
            .o_head_vld     (w_head_vld[g]),
            .o_head_tag     (w_head_tag[g]),
            .o_head_value   (w_head_value[g]),
            .o_head_rob_idx (w_head_rob[g]),
            .o_full         (src_full_o[g]),
            .o_ovf          (w_ovf[g])
        );
    end

    // First non-empty head at or after rr_ptr. No grant during recovery
    // (heads may be squashed) or reset (queues are being discarded).
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = r_rr_ptr;
        for (int unsigned off = 0; off < NUM_SRC; off++) begin
            if (!w_grant_vld && w_head_vld[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
            w_cand = next_src(w_cand);
        end
        if (rst || rob_br_recovery_i) begin
            w_grant_vld = 1'b0;
        end
    end

    always_comb begin
        cdb_vld_o     = w_grant_vld;
        cdb_tag_o     = ZERO_REG;
        cdb_value_o   = '0;
        cdb_rob_idx_o = '0;
        if (w_grant_vld) begin
            cdb_tag_o     = w_head_tag[w_grant_idx];
            cdb_value_o   = w_head_value[w_grant_idx];
            cdb_rob_idx_o = w_head_rob[w_grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_grant_vld) begin
                r_rr_ptr <= next_src(w_grant_idx);
            end
            if (|w_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign ovf_err_o = r_ovf;

endmodule

// File: tb/tb_fu_cdb_arb.sv
// tb_fu_cdb_arb: directed scenarios for fu_cdb_arb (QDEPTH=2) with
// hand-computed expected broadcast sequences.
module tb_fu_cdb_arb;
    import fu_cdb_arb_pkg::*;

    logic                               clk;
    logic                               rst;
    logic [NUM_SRC-1:0]                 src_vld_i;
    logic [NUM_SRC-1:0][PRF_IDX_W-1:0]  src_tag_i;
    logic [NUM_SRC-1:0][63:0]           src_value_i;
    logic [NUM_SRC-1:0][ROB_IDX_W-1:0]  src_rob_idx_i;
    logic [NUM_SRC-1:0][BR_MASK_W-1:0]  src_br_mask_i;
    logic                               rob_br_recovery_i;
    logic                               rob_br_pred_correct_i;
    logic [BR_MASK_W-1:0]               rob_br_tag_fix_i;
    logic [NUM_SRC-1:0]                 src_full_o;
    logic                               cdb_vld_o;
    logic [PRF_IDX_W-1:0]               cdb_tag_o;
    logic [63:0]                        cdb_value_o;
    logic [ROB_IDX_W-1:0]               cdb_rob_idx_o;
    logic                               ovf_err_o;
    logic [75:0]                        w_cdb;

    int total;
    int bad;

    fu_cdb_arb #(
        .QDEPTH (2)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .src_vld_i             (src_vld_i),
        .src_tag_i             (src_tag_i),
        .src_value_i           (src_value_i),
        .src_rob_idx_i         (src_rob_idx_i),
        .src_br_mask_i         (src_br_mask_i),
        .rob_br_recovery_i     (rob_br_recovery_i),
        .rob_br_pred_correct_i (rob_br_pred_correct_i),
        .rob_br_tag_fix_i      (rob_br_tag_fix_i),
        .src_full_o            (src_full_o),
        .cdb_vld_o             (cdb_vld_o),
        .cdb_tag_o             (cdb_tag_o),
        .cdb_value_o           (cdb_value_o),
        .cdb_rob_idx_o         (cdb_rob_idx_o),
        .ovf_err_o             (ovf_err_o)
    );

    assign w_cdb = {cdb_vld_o, cdb_tag_o, cdb_value_o, cdb_rob_idx_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] val_of(input logic [5:0] t);
        return 64'hC0DE_0000_0000_0000 | {58'd0, t};
    endfunction

    function automatic logic [4:0] rob_of(input logic [5:0] t);
        return t[4:0] ^ 5'h15;
    endfunction

    // Expected {vld, tag, value, rob_idx}; t < 0 means no broadcast.
    function automatic logic [75:0] exp_cdb(input int t);
        logic [5:0] tg;
        if (t < 0) return '0;
        tg = 6'(t);
        return {1'b1, tg, val_of(tg), rob_of(tg)};
    endfunction

    task automatic clear_inputs();
        src_vld_i             = '0;
        src_tag_i             = '0;
        src_value_i           = '0;
        src_rob_idx_i         = '0;
        src_br_mask_i         = '0;
        rob_br_recovery_i     = 1'b0;
        rob_br_pred_correct_i = 1'b0;
        rob_br_tag_fix_i      = '0;
    endtask

    task automatic drive(input int unsigned s, input int t, input logic [3:0] m);
        logic [5:0] tg;
        tg               = 6'(t);
        src_vld_i[s]     = 1'b1;
        src_tag_i[s]     = tg;
        src_value_i[s]   = val_of(tg);
        src_rob_idx_i[s] = rob_of(tg);
        src_br_mask_i[s] = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(SRC_ALU, 1, 4'b0000);
        drive(SRC_MULT, 2, 4'b0000);
        drive(SRC_LD, 3, 4'b0000);
        tick();
        rst = 1'b1;
        drive(SRC_ALU, 4, 4'b0000);
        tick();
        rst = 1'b0;
        settle();
        total++;
        if (w_cdb !== 76'd0) begin
            bad++;
            $display("FAIL reset_cdb got=%h exp=%h", w_cdb, 76'd0);
        end
        total++;
        if (src_full_o !== 3'b000) begin
            bad++;
            $display("FAIL reset_full got=%b exp=000", src_full_o);
        end
        total++;
        if (ovf_err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf got=%b exp=0", ovf_err_o);
        end
        tick();
        settle();
        total++;
        if (cdb_vld_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ignored_push got vld=%b exp=0", cdb_vld_o);
        end
        tick();
    endtask

    task automatic test_rr();
        int exp_t [9] = '{-1, 5, 6, 7, -1, -1, 8, 9, -1};
        for (int c = 0; c < 9; c++) begin
            if (c == 0) begin
                drive(SRC_ALU, 5, 4'b0000);
                drive(SRC_MULT, 6, 4'b0000);
                drive(SRC_LD, 7, 4'b0000);
            end
            if (c == 5) begin
                drive(SRC_ALU, 8, 4'b0000);
                drive(SRC_LD, 9, 4'b0000);
            end
            settle();
            total++;
            if (w_cdb !== exp_cdb(exp_t[c])) begin
                bad++;
                $display("FAIL rr_cdb c=%0d got=%h exp=%h", c, w_cdb, exp_cdb(exp_t[c]));
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        int exp_t [8] = '{10, 40, 20, 30, 21, 31, 22, -1};
        do_reset();
        drive(SRC_MULT, 10, 4'b0000);
        tick();
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: begin
                    drive(SRC_ALU, 20, 4'b0000);
                    drive(SRC_MULT, 30, 4'b0000);
                    drive(SRC_LD, 40, 4'b0000);
                end
                1: begin
                    drive(SRC_ALU, 21, 4'b0000);
                    drive(SRC_MULT, 31, 4'b0000);
                end
                2: begin
                    drive(SRC_ALU, 22, 4'b0000);
                    drive(SRC_MULT, 32, 4'b0000);
                end
                default: ;
            endcase
            settle();
            total++;
            if (w_cdb !== exp_cdb(exp_t[c])) begin
                bad++;
                $display("FAIL ovf_cdb c=%0d got=%h exp=%h", c, w_cdb, exp_cdb(exp_t[c]));
            end
            if (c == 1) begin
                total++;
                if (src_full_o !== 3'b000) begin
                    bad++;
                    $display("FAIL ovf_full_c1 got=%b exp=000", src_full_o);
                end
            end
            if (c == 2 || c == 3) begin
                total++;
                if (src_full_o !== 3'b011) begin
                    bad++;
                    $display("FAIL ovf_full c=%0d got=%b exp=011", c, src_full_o);
                end
                total++;
                if (ovf_err_o !== (c == 3)) begin
                    bad++;
                    $display("FAIL ovf_flag c=%0d got=%b exp=%b", c, ovf_err_o, (c == 3));
                end
            end
            tick();
        end
        settle();
        total++;
        if (ovf_err_o !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky got=%b exp=1", ovf_err_o);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin
                drive(SRC_ALU, 50, 4'b0000);
                drive(SRC_MULT, 51, 4'b0000);
                drive(SRC_LD, 52, 4'b0000);
            end
            if (c == 1) begin
                drive(SRC_ALU, 53, 4'b0000);
                drive(SRC_MULT, 54, 4'b0000);
                drive(SRC_LD, 55, 4'b0000);
            end
            if (c == 2) begin
                rst = 1'b1;
                drive(SRC_ALU, 60, 4'b0000);
                drive(SRC_MULT, 61, 4'b0000);
                drive(SRC_LD, 62, 4'b0000);
            end
            settle();
            if (c == 1) begin
                total++;
                if (w_cdb !== exp_cdb(51)) begin
                    bad++;
                    $display("FAIL mrst_pre_cdb got=%h exp=%h", w_cdb, exp_cdb(51));
                end
            end
            if (c == 2) begin
                total++;
                if (src_full_o !== 3'b101) begin
                    bad++;
                    $display("FAIL mrst_pre_full got=%b exp=101", src_full_o);
                end
                total++;
                if (ovf_err_o !== 1'b1) begin
                    bad++;
                    $display("FAIL mrst_pre_ovf got=%b exp=1", ovf_err_o);
                end
            end
            if (c == 3) begin
                total++;
                if (src_full_o !== 3'b000) begin
                    bad++;
                    $display("FAIL mrst_full got=%b exp=000", src_full_o);
                end
                total++;
                if (ovf_err_o !== 1'b0) begin
                    bad++;
                    $display("FAIL mrst_ovf got=%b exp=0", ovf_err_o);
                end
            end
            if (c >= 3) begin
                total++;
                if (w_cdb !== 76'd0) begin
                    bad++;
                    $display("FAIL mrst_cdb c=%0d got=%h exp=%h", c, w_cdb, 76'd0);
                end
            end
            tick();
            rst = 1'b0;
        end
    endtask

    task automatic test_recovery();
        int exp_t [6] = '{-1, 1, -1, 12, 14, -1};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin
                    drive(SRC_ALU, 1, 4'b0000);
                    drive(SRC_LD, 11, 4'b0010);
                end
                1: drive(SRC_LD, 12, 4'b0001);
                2: begin
                    rob_br_recovery_i = 1'b1;
                    rob_br_tag_fix_i  = 4'b0010;
                    drive(SRC_ALU, 14, 4'b0100);
                    drive(SRC_MULT, 13, 4'b0010);
                end
                default: ;
            endcase
            settle();
            total++;
            if (w_cdb !== exp_cdb(exp_t[c])) begin
                bad++;
                $display("FAIL recov_cdb c=%0d got=%h exp=%h", c, w_cdb, exp_cdb(exp_t[c]));
            end
            if (c == 2) begin
                total++;
                if (src_full_o !== 3'b100) begin
                    bad++;
                    $display("FAIL recov_full_c2 got=%b exp=100", src_full_o);
                end
            end
            if (c == 3) begin
                total++;
                if (src_full_o !== 3'b000) begin
                    bad++;
                    $display("FAIL recov_full_c3 got=%b exp=000", src_full_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_pred_correct();
        int exp_t [6] = '{-1, 20, -1, 21, -1, -1};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin
                    drive(SRC_ALU, 20, 4'b0000);
                    drive(SRC_LD, 21, 4'b0110);
                end
                1: begin
                    rob_br_pred_correct_i = 1'b1;
                    rob_br_tag_fix_i      = 4'b0100;
                    drive(SRC_LD, 22, 4'b0110);
                end
                2: begin
                    rob_br_recovery_i = 1'b1;
                    rob_br_tag_fix_i  = 4'b0100;
                end
                4: begin
                    rob_br_recovery_i = 1'b1;
                    rob_br_tag_fix_i  = 4'b0010;
                end
                default: ;
            endcase
            settle();
            total++;
            if (w_cdb !== exp_cdb(exp_t[c])) begin
                bad++;
                $display("FAIL pc_cdb c=%0d got=%h exp=%h", c, w_cdb, exp_cdb(exp_t[c]));
            end
            if (c == 2) begin
                total++;
                if (src_full_o !== 3'b100) begin
                    bad++;
                    $display("FAIL pc_full_c2 got=%b exp=100", src_full_o);
                end
            end
            if (c == 5) begin
                total++;
                if (src_full_o !== 3'b000) begin
                    bad++;
                    $display("FAIL pc_full_c5 got=%b exp=000", src_full_o);
                end
            end
            tick();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_rr();
        test_overflow();
        test_mid_reset();
        test_recovery();
        test_pred_correct();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
